// File: rtl/conv2_dw_pkg.sv
// Shared widths, window types and channel-major window packing for the conv2 depthwise path.
package conv2_dw_pkg;

    localparam int CH       = 8;
    localparam int ACT_W    = 8;
    localparam int K        = 3;
    localparam int WIN_TAPS = K * K;

    typedef logic [CH*ACT_W-1:0]          pix_t;
    typedef logic [WIN_TAPS*CH*ACT_W-1:0] win_t;

    // Tap-major taps in, channel-major window out: channel c tap k at [(c*9+k)*ACT_W +: ACT_W].
    function automatic win_t pack_win(input pix_t taps [WIN_TAPS]);
        win_t w;
        w = '0;
        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < WIN_TAPS; k++) begin
                w[(c*WIN_TAPS+k)*ACT_W +: ACT_W] = taps[k][c*ACT_W +: ACT_W];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/conv2_dw_window_linebuf.sv
// One raster line of pixels: combinational read and synchronous write at a shared address.
module conv2_dw_linebuf #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Reading the old word while writing the same address is what makes the line delay work.
    assign rdata = mem[addr];

    // NOTE: the array has no reset; stale lines are never used before being rewritten,
    // and leaving it unreset lets it map onto plain storage.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/conv2_dw_window.sv
// 3x3xCH sliding-window generator feeding the conv2 depthwise stage (stride 1, valid conv).
// Define CONV2_DW_WIN_STRIDE2_EN to emit windows only at even (row,col).
module conv2_dw_window #(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16,
    parameter int CH    = conv2_dw_pkg::CH,
    parameter int ACT_W = conv2_dw_pkg::ACT_W
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      in_valid,
    input  logic                                      in_sof,
    input  logic [CH*ACT_W-1:0]                       in_pix,
    output logic                                      out_valid,
    output logic [conv2_dw_pkg::WIN_TAPS*CH*ACT_W-1:0] out_win,
    output logic                                      frame_done,
    output logic                                      sof_err
);

    import conv2_dw_pkg::K;
    import conv2_dw_pkg::WIN_TAPS;

    localparam int PW = CH * ACT_W;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0] col, eff_col;
    logic [RW-1:0] row, eff_row;
    logic          at_origin, last_col, last_row, win_ok;
    logic [PW-1:0] lb0_rd, lb1_rd;
    logic [PW-1:0] win_q [WIN_TAPS];
    logic [PW-1:0] win_d [WIN_TAPS];
    logic [WIN_TAPS*PW-1:0] win_packed;

    // A start-of-frame beat is always pixel (0,0), whatever the counters say.
    assign eff_col   = in_sof ? '0 : col;
    assign eff_row   = in_sof ? '0 : row;
    assign at_origin = (col == '0) && (row == '0);
    assign last_col  = (eff_col == CW'(IMG_W - 1));
    assign last_row  = (eff_row == RW'(IMG_H - 1));

`ifdef CONV2_DW_WIN_STRIDE2_EN
    assign win_ok = in_valid && (eff_row >= RW'(2)) && (eff_col >= CW'(2))
                    && !eff_row[0] && !eff_col[0];
`else
    assign win_ok = in_valid && (eff_row >= RW'(2)) && (eff_col >= CW'(2));
`endif

    conv2_dw_linebuf #(.DEPTH(IMG_W), .WIDTH(PW)) u_lb0 (
        .clk   (clk),
        .we    (in_valid),
        .addr  (eff_col),
        .wdata (in_pix),
        .rdata (lb0_rd)
    );

    conv2_dw_linebuf #(.DEPTH(IMG_W), .WIDTH(PW)) u_lb1 (
        .clk   (clk),
        .we    (in_valid),
        .addr  (eff_col),
        .wdata (lb0_rd),
        .rdata (lb1_rd)
    );

    // Next window: columns shift left, new rightmost column is {row-2, row-1, row}.
    // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
    always_comb begin
        for (int ky = 0; ky < K; ky++) begin
            for (int kx = 0; kx < K - 1; kx++) begin
                win_d[ky*K+kx] = win_q[ky*K+kx+1];
            end
        end
        win_d[0*K+K-1] = lb1_rd;
        win_d[1*K+K-1] = lb0_rd;
        win_d[2*K+K-1] = in_pix;
    end

    always_comb begin
        win_packed = '0;
        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < WIN_TAPS; k++) begin
                win_packed[(c*WIN_TAPS+k)*ACT_W +: ACT_W] = win_d[k][c*ACT_W +: ACT_W];
            end
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            sof_err    <= 1'b0;
            out_win    <= '0;
            for (int k = 0; k < WIN_TAPS; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            out_valid  <= win_ok;
            frame_done <= in_valid && last_row && last_col;
            sof_err    <= in_valid && in_sof && !at_origin;
            if (win_ok) begin
                out_win <= win_packed;
            end
            if (in_valid) begin
                for (int k = 0; k < WIN_TAPS; k++) begin
                    win_q[k] <= win_d[k];
                end
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : eff_row + RW'(1);
                end else begin
                    col <= eff_col + CW'(1);
                    row <= eff_row;
                end
            end
        end
    end

endmodule
